// File: rtl/occupancy_counter_bcd_if.sv
// Event/status bundle between the entry/exit detectors, the occupancy counter and the HEX displays.
// HEX5..HEX0 are active-low segment vectors, bit6=a ... bit0=g.
interface occupancy_counter_bcd_if #(
  parameter int CW = 7
);
  logic          inc;
  logic          dec;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          reject;
  logic [6:0]    HEX0;
  logic [6:0]    HEX1;
  logic [6:0]    HEX2;
  logic [6:0]    HEX3;
  logic [6:0]    HEX4;
  logic [6:0]    HEX5;

  modport master (
    output inc, dec,
    input  count, full, empty, reject, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  inc, dec,
    output count, full, empty, reject, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/occupancy_counter_bcd.sv
// Saturating 0..CAPACITY occupancy counter with BCD shadow digits and a registered six-digit HEX status frame.
// Optional macro OCC_LEADING_BLANK_EN blanks HEX1 when tens==0 in NORMAL/FULL modes.
module occupancy_counter_bcd #(
  parameter int CAPACITY = 25,
  parameter int CW       = 7
) (
  input logic                     clk,
  input logic                     reset,
  occupancy_counter_bcd_if.slave  bus
);

  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  localparam logic [6:0] G_C     = 7'b0110001;
  localparam logic [6:0] G_L     = 7'b1110001;
  localparam logic [6:0] G_E     = 7'b0110000;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_R     = 7'b1111010;
  localparam logic [6:0] G_F     = 7'b0111000;
  localparam logic [6:0] G_U     = 7'b1000001;
  localparam logic [6:0] G_0     = 7'b0000001;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  localparam logic [5:0][6:0] FRAME_CLEAR = {G_C, G_L, G_E, G_A, G_R, G_0};

  if (CAPACITY < 1 || CAPACITY > 99) begin : g_bad_capacity
    $error("occupancy_counter_bcd: CAPACITY %0d outside 1..99", CAPACITY);
  end
  if ((64'd1 << CW) <= 64'(CAPACITY)) begin : g_bad_cw
    $error("occupancy_counter_bcd: CW %0d too narrow for CAPACITY %0d", CW, CAPACITY);
  end

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 7'b0000001;
      4'd1:    digit_glyph = 7'b1001111;
      4'd2:    digit_glyph = 7'b0010010;
      4'd3:    digit_glyph = 7'b0000110;
      4'd4:    digit_glyph = 7'b1001100;
      4'd5:    digit_glyph = 7'b0100100;
      4'd6:    digit_glyph = 7'b0100000;
      4'd7:    digit_glyph = 7'b0001111;
      4'd8:    digit_glyph = 7'b0000000;
      4'd9:    digit_glyph = 7'b0000100;
      default: digit_glyph = G_BLANK;
    endcase
  endfunction

  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      ones_q, ones_d;
  logic [3:0]      tens_q, tens_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            reject_q, reject_d;
  logic [5:0][6:0] hex_q, hex_d;
  logic [6:0]      tens_glyph;

  // BCD digits follow count by carry/borrow so the display never needs a divider.
  always_comb begin
    count_d  = count_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
    reject_d = 1'b0;
    if (bus.inc && !bus.dec) begin
      if (full_q) begin
        reject_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end else if (bus.dec && !bus.inc) begin
      if (empty_q) begin
        reject_d = 1'b1;
      end else begin
        count_d = count_q - CW'(1);
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
    full_d  = (count_d == CAP);
    empty_d = (count_d == '0);
  end

  always_comb begin
`ifdef OCC_LEADING_BLANK_EN
    tens_glyph = (tens_q == 4'd0) ? G_BLANK : digit_glyph(tens_q);
`else
    tens_glyph = digit_glyph(tens_q);
`endif
    if (empty_q) begin
      hex_d = FRAME_CLEAR;
    end else if (full_q) begin
      hex_d = {G_F, G_U, G_L, G_L, tens_glyph, digit_glyph(ones_q)};
    end else begin
      hex_d = {G_BLANK, G_BLANK, G_BLANK, G_BLANK, tens_glyph, digit_glyph(ones_q)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      ones_q   <= 4'd0;
      tens_q   <= 4'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      reject_q <= 1'b0;
      hex_q    <= FRAME_CLEAR;
    end else begin
      count_q  <= count_d;
      ones_q   <= ones_d;
      tens_q   <= tens_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      reject_q <= reject_d;
      hex_q    <= hex_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.full   = full_q;
  assign bus.empty  = empty_q;
  assign bus.reject = reject_q;
  assign bus.HEX0   = hex_q[0];
  assign bus.HEX1   = hex_q[1];
  assign bus.HEX2   = hex_q[2];
  assign bus.HEX3   = hex_q[3];
  assign bus.HEX4   = hex_q[4];
  assign bus.HEX5   = hex_q[5];

endmodule

// File: doc/occupancy_counter_bcd.md
Name: occupancy_counter_bcd

Overview:
Parametrised saturating occupancy counter with a BCD six-digit HEX status display.
- Tracks occupancy 0..CAPACITY from single-cycle inc/dec event pulses. Rejects events that would overflow or underflow.
- Drives HEX5..HEX0 with "CLEAr0", "FULL" plus the count, or the bare count.
- Sits between the entry/exit event detectors and the board seven-segment displays.

Parameters:
CAPACITY, 25, maximum occupancy; legal range 1..99; out-of-range values raise an $error at elaboration.
CW, 7, width of the binary count output; must satisfy 2**CW > CAPACITY.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
inc  input  1  arrival event, sampled every cycle
dec  input  1  departure event, sampled every cycle
count  output  CW  binary occupancy, registered
full  output  1  high when count == CAPACITY, registered
empty  output  1  high when count == 0, registered
reject  output  1  one-cycle pulse when an event is refused, registered
HEX0..HEX5  output  7 each  active-low segments; bit6=a ... bit0=g; registered

Behaviour:
- Reset is sampled on the clk edge and overrides all other inputs. After reset:
  - count=0, ones=0, tens=0, empty=1, full=0, reject=0.
  - HEX5..HEX0 = C,L,E,A,r,0.
- Per-edge event decode:
  - inc & ~dec & ~full: count+1.
  - dec & ~inc & ~empty: count-1.
  - inc & dec: hold; reject=0. Net zero change; this holds at full and at empty too.
  - inc & ~dec & full: hold; reject=1 for one cycle.
  - dec & ~inc & empty: hold; reject=1 for one cycle.
  - Neither input asserted: hold; reject=0.
- BCD state: ones[3:0] and tens[3:0] are kept in step with count by carry/borrow, not by division.
  - Increment: ones 9→0 with tens+1.
  - Decrement: ones 0→9 with tens-1.
  - Invariant at every edge: 10*tens + ones == count.
- full and empty are registered with count on the same edge. They reflect the new count. No wrap-around is possible.
- Latency:
  - count, full, empty and reject update on the edge that samples the event.
  - HEX outputs update one edge later from the registered state (total 2 edges from event to display).
- Display modes, selected from the registered state:
  - EMPTY (count==0): HEX5..HEX1 = C,L,E,A,r; HEX0 = digit 0.
  - FULL (count==CAPACITY): HEX5..HEX2 = F,U,L,L; HEX1 = tens digit; HEX0 = ones digit.
  - NORMAL: HEX5..HEX2 blank; HEX1 = tens digit; HEX0 = ones digit.
  - When CAPACITY==1 the count reaches 1 and the display is in FULL mode.
- Glyphs (active-low, abcdefg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, C=0110001, L=1110001, E=0110000, A=0001000, r=1111010, F=0111000, U=1000001, blank=1111111.
- Reset mid-operation: all state returns to reset values on that edge. The HEX pipeline stage also reloads "CLEAr0" on the same edge; no stale frame is shown.

Optional Feature:
Macro OCC_LEADING_BLANK_EN.
- Defined: in NORMAL and FULL modes, HEX1 is blank when tens==0. Example: count 7 shows "____ _7".
- Undefined: HEX1 always shows the tens digit. Example: count 7 shows "____07".
- EMPTY mode is identical in both builds.

Test Plan:
1. Reset for 2 cycles, then idle → count=0, empty=1, full=0, reject=0; HEX5..HEX0 = 0110001,1110001,0110000,0001000,1111010,0000001.
2. CAPACITY=25: inc held for 26 cycles → count reaches 25 on the 25th edge with full=1; reject=1 on the 26th edge only; count stays 25; HEX = F,U,L,L,2,5.
3. From 10, one dec → count=9, tens=0, ones=9 (borrow path); display is blank×4,0,9 (blank×5,9 with OCC_LEADING_BLANK_EN).
4. inc=dec=1 for 3 cycles at count 0, at count 12 and at count 25 → count unchanged and reject=0 throughout.
5. At count 0, dec pulse → reject=1 for exactly 1 cycle; count=0; display stays CLEAr0.
6. At count 17, assert reset for 1 cycle while inc=1 → next edge count=0 and empty=1; HEX shows CLEAr0; inc in the following cycle gives count=1.
